// File: rtl/ram_io_responder.sv
// Board-side responder for the CPU byte bus: byte RAM plus a memory-mapped I/O window
// with UART TX/RX FIFOs, a free-running cycle counter with coherent snapshot, and program-stop.
module ram_io_responder #(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned TX_DEPTH_W = 4,
  parameter int unsigned RX_DEPTH_W = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam logic [TX_DEPTH_W:0] TX_FULL = (TX_DEPTH_W+1)'(1 << TX_DEPTH_W);
  localparam logic [TX_DEPTH_W:0] TX_HIGH = TX_FULL - (TX_DEPTH_W+1)'(2);
  localparam logic [RX_DEPTH_W:0] RX_FULL = (RX_DEPTH_W+1)'(1 << RX_DEPTH_W);

  logic                  io_sel;
  logic [15:0]           reg_off;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  unused_addr;

  assign io_sel      = (cpu_a[17:16] == 2'b11);
  assign reg_off     = cpu_a[15:0];
  assign ram_idx     = cpu_a[RAM_ADDR_W-1:0];
  assign unused_addr = ^cpu_a[31:18];

  logic wr_txd, wr_stop, rd_rxd, rd_cnt, ram_we;

  assign wr_txd  = io_sel & cpu_wr & (reg_off == 16'h0000) & (cpu_wdata != 8'h00);
  assign wr_stop = io_sel & cpu_wr & (reg_off == 16'h0004);
  assign rd_rxd  = io_sel & ~cpu_wr & (reg_off == 16'h0000);
  assign rd_cnt  = io_sel & ~cpu_wr & (reg_off == 16'h0004);
  assign ram_we  = ~rst_in & cpu_wr & ~io_sel;

  // RAM kept free of reset so it can map onto block memory; cpu_rdata is a mux of two registers.
  logic [7:0] ram [1 << RAM_ADDR_W];
  logic [7:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= cpu_wdata;
    ram_q <= ram[ram_idx];
  end

  // TX FIFO
  logic [7:0]            tx_mem [1 << TX_DEPTH_W];
  logic [TX_DEPTH_W-1:0] tx_wptr, tx_rptr;
  logic [TX_DEPTH_W:0]   tx_count;
  logic                  tx_push_req, tx_push, tx_pop, tx_full;
  logic [7:0]            tx_byte;

  assign tx_full        = (tx_count == TX_FULL);
  assign tx_valid       = (tx_count != '0);
  assign tx_data        = tx_mem[tx_rptr];
  assign tx_pop         = tx_valid & tx_ready;
  assign tx_push_req    = wr_txd | wr_stop;
  assign tx_byte        = wr_stop ? 8'h00 : cpu_wdata;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign tx_push        = tx_push_req & (~tx_full | tx_pop);
  assign io_buffer_full = (tx_count >= TX_HIGH);

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wptr] <= tx_byte;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + TX_DEPTH_W'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + TX_DEPTH_W'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_DEPTH_W+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_DEPTH_W+1)'(1);
        default: tx_count <= tx_count;
      endcase
      if (tx_push_req & ~tx_push) tx_overflow <= 1'b1;
    end
  end

  // RX FIFO
  logic [7:0]            rx_mem [1 << RX_DEPTH_W];
  logic [RX_DEPTH_W-1:0] rx_wptr, rx_rptr;
  logic [RX_DEPTH_W:0]   rx_count;
  logic                  rx_push, rx_pop, rx_empty;

  assign rx_empty = (rx_count == '0);
  assign rx_ready = (rx_count != RX_FULL);
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_rxd & ~rx_empty;

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + RX_DEPTH_W'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + RX_DEPTH_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_DEPTH_W+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_DEPTH_W+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Counter, snapshot, I/O read data
  logic [31:0] cycle_count;
  logic [31:8] snapshot_hi;
  logic [7:0]  io_byte, io_q;
  logic        sel_ram_q;

  always_comb begin
    io_byte = 8'h00;
    if (io_sel) begin
      case (reg_off)
        16'h0000: io_byte = rx_empty ? 8'h00 : rx_mem[rx_rptr];
        16'h0004: io_byte = cycle_count[7:0];
        16'h0005: io_byte = snapshot_hi[15:8];
        16'h0006: io_byte = snapshot_hi[23:16];
        16'h0007: io_byte = snapshot_hi[31:24];
        default:  io_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_count  <= '0;
      snapshot_hi  <= '0;
      program_stop <= 1'b0;
      io_q         <= '0;
      sel_ram_q    <= 1'b0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (rd_cnt)  snapshot_hi  <= cycle_count[31:8];
      if (wr_stop) program_stop <= 1'b1;
      io_q      <= cpu_wr ? 8'h00 : io_byte;
      sel_ram_q <= ~cpu_wr & ~io_sel;
    end
  end

  assign cpu_rdata = sel_ram_q ? ram_q : io_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Bench for ram_io_responder: vector table, directed corner sequences, and randomized
// traffic checked against a queue-based reference model.
module tb_ram_io_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full, tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, program_stop, tx_overflow;

  ram_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH_W(4), .RX_DEPTH_W(4)) dut (
    .clk_in(clk), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .io_buffer_full(io_buffer_full), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0]  m_ram [int];
  logic [7:0]  m_tx [$];
  logic [7:0]  m_rx [$];
  logic [31:0] m_cnt, m_snap;
  logic        m_stop, m_ovf, m_chk;
  logic [7:0]  m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic        io, tx_pop, rx_push, was_full, push_req;
    logic [17:0] a18;
    logic [7:0]  pv;
    if (rst_in) begin
      m_tx.delete(); m_rx.delete();
      m_cnt = 0; m_snap = 0; m_stop = 0; m_ovf = 0; m_chk = 1; m_rdata = 0;
      return;
    end
    a18      = cpu_a[17:0];
    io       = (a18[17:16] == 2'b11);
    tx_pop   = (m_tx.size() != 0) && tx_ready;
    rx_push  = rx_valid && (m_rx.size() < 16);
    was_full = (m_tx.size() == 16);
    push_req = 0; pv = 0; m_chk = 0;
    if (cpu_wr) begin
      if (!io) m_ram[int'(a18[16:0])] = cpu_wdata;
      else if (a18 == 18'h30000 && cpu_wdata != 0) begin push_req = 1; pv = cpu_wdata; end
      else if (a18 == 18'h30004) begin push_req = 1; pv = 8'h00; m_stop = 1; end
    end else begin
      m_chk = 1;
      if (!io) begin
        if (m_ram.exists(int'(a18[16:0]))) m_rdata = m_ram[int'(a18[16:0])];
        else m_chk = 0;
      end else begin
        case (a18)
          18'h30000: m_rdata = (m_rx.size() != 0) ? m_rx.pop_front() : 8'h00;
          18'h30004: begin m_rdata = m_cnt[7:0]; m_snap = m_cnt; end
          18'h30005: m_rdata = m_snap[15:8];
          18'h30006: m_rdata = m_snap[23:16];
          18'h30007: m_rdata = m_snap[31:24];
          default:   m_rdata = 8'h00;
        endcase
      end
    end
    if (tx_pop) void'(m_tx.pop_front());
    if (push_req) begin
      if (!was_full || tx_pop) m_tx.push_back(pv);
      else m_ovf = 1;
    end
    if (rx_push) m_rx.push_back(rx_data);
    m_cnt = m_cnt + 1;
  endtask

  task automatic model_check();
    check("m.tx_valid", 32'(tx_valid), 32'(m_tx.size() != 0));
    if (m_tx.size() != 0) check("m.tx_data", 32'(tx_data), 32'(m_tx[0]));
    check("m.io_buffer_full", 32'(io_buffer_full), 32'(m_tx.size() >= 14));
    check("m.rx_ready", 32'(rx_ready), 32'(m_rx.size() < 16));
    check("m.program_stop", 32'(program_stop), 32'(m_stop));
    check("m.tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    if (m_chk) check("m.rdata", 32'(cpu_rdata), 32'(m_rdata));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic idle();
    cpu_a = 32'h0003_0008; cpu_wr = 1'b0; cpu_wdata = 8'h00;
  endtask

  task automatic reset_dut();
    idle(); rst_in = 1'b1; cycle(); rst_in = 1'b0;
  endtask

  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] wd);
    cpu_a = a; cpu_wr = wr; cpu_wdata = wd;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  wd;
    logic        rxv;
    logic [7:0]  rxd;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [31:0] rand_ram_addr();
    case ($urandom % 4)
      0:       return 32'h0000_0010;
      1:       return 32'h0001_FFFF;
      2:       return 32'h0002_0000 | 32'($urandom % 8);
      default: return 32'($urandom % 8);
    endcase
  endfunction

  initial begin
    int got;
    vecs[0]  = '{32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[2]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3C};
    vecs[4]  = '{32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[5]  = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h31, 1'b1, 8'h3C};
    vecs[6]  = '{32'h0003_0010, 1'b0, 8'h00, 1'b1, 8'h32, 1'b1, 8'h00};
    vecs[7]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h31};
    vecs[8]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h32};
    vecs[9]  = '{32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[10] = '{32'h0003_0003, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};

    rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle();
    cycle();
    rst_in = 1'b0;
    check("rst.rdata", 32'(cpu_rdata), 32'h00);
    check("rst.tx_valid", 32'(tx_valid), 32'h0);
    check("rst.rx_ready", 32'(rx_ready), 32'h1);
    check("rst.io_buffer_full", 32'(io_buffer_full), 32'h0);
    check("rst.program_stop", 32'(program_stop), 32'h0);
    check("rst.tx_overflow", 32'(tx_overflow), 32'h0);

    for (int i = 0; i < 11; i++) begin
      bus(vecs[i].a, vecs[i].wr, vecs[i].wd);
      rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
      cycle();
      if (vecs[i].chk) check($sformatf("vec%0d.rdata", i), 32'(cpu_rdata), 32'(vecs[i].exp));
    end
    rx_valid = 1'b0;

    // TX: 'H','i', then a zero byte that must be ignored
    bus(32'h0003_0000, 1'b1, 8'h48); cycle();
    bus(32'h0003_0000, 1'b1, 8'h69); cycle();
    bus(32'h0003_0000, 1'b1, 8'h00); cycle();
    idle();
    check("tx.hi.valid", 32'(tx_valid), 32'h1);
    check("tx.hi.head", 32'(tx_data), 32'h48);
    tx_ready = 1'b1; cycle();
    check("tx.hi.second", 32'(tx_data), 32'h69);
    check("tx.hi.valid2", 32'(tx_valid), 32'h1);
    cycle();
    check("tx.hi.empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // TX fill to full, then one overflowing write
    for (int k = 1; k <= 16; k++) begin
      bus(32'h0003_0000, 1'b1, 8'(k)); cycle();
      check($sformatf("txfill%0d.ibf", k), 32'(io_buffer_full), 32'(k >= 14));
    end
    bus(32'h0003_0000, 1'b1, 8'hEE); cycle();
    check("txfull.overflow", 32'(tx_overflow), 32'h1);
    idle();
    tx_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 40 && tx_valid; k++) begin
      check("txdrain.data", 32'(tx_data), 32'(got + 1));
      got++;
      cycle();
    end
    check("txdrain.count", 32'(got), 32'd16);
    tx_ready = 1'b0;
    reset_dut();
    check("txfull.ovf_cleared", 32'(tx_overflow), 32'h0);

    // RX fill to full; extra byte is held off
    rx_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_data = 8'(8'h40 + i); cycle();
      check($sformatf("rxfill%0d.ready", i), 32'(rx_ready), 32'(i < 15));
    end
    rx_data = 8'h99; cycle();
    check("rxfull.held", 32'(rx_ready), 32'h0);
    rx_valid = 1'b0;
    bus(32'h0003_0000, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cycle();
      check($sformatf("rxread%0d", i), 32'(cpu_rdata), 32'(8'h40 + i));
    end
    cycle();
    check("rxread.empty", 32'(cpu_rdata), 32'h00);

    // Counter snapshot at 0x000001FF
    reset_dut();
    for (int k = 0; k < 1000 && m_cnt != 32'h1FF; k++) cycle();
    bus(32'h0003_0004, 1'b0, 8'h00); cycle(); check("cnt.b0", 32'(cpu_rdata), 32'hFF);
    bus(32'h0003_0005, 1'b0, 8'h00); cycle(); check("cnt.b1", 32'(cpu_rdata), 32'h01);
    bus(32'h0003_0006, 1'b0, 8'h00); cycle(); check("cnt.b2", 32'(cpu_rdata), 32'h00);
    bus(32'h0003_0007, 1'b0, 8'h00); cycle(); check("cnt.b3", 32'(cpu_rdata), 32'h00);

    // Counter wrap
    idle();
    force dut.cycle_count = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_count;
    m_cnt = 32'hFFFF_FFFE;
    bus(32'h0003_0004, 1'b0, 8'h00); cycle(); check("wrap.fe", 32'(cpu_rdata), 32'hFE);
    cycle(); check("wrap.ff", 32'(cpu_rdata), 32'hFF);
    bus(32'h0003_0007, 1'b0, 8'h00); cycle(); check("wrap.snap_hi", 32'(cpu_rdata), 32'hFF);
    bus(32'h0003_0004, 1'b0, 8'h00); cycle(); check("wrap.zero", 32'(cpu_rdata), 32'h01);
    bus(32'h0003_0007, 1'b0, 8'h00); cycle(); check("wrap.snap_zero", 32'(cpu_rdata), 32'h00);

    // Program stop
    tx_ready = 1'b1;
    bus(32'h0003_0004, 1'b1, 8'h77); cycle();
    check("stop.set", 32'(program_stop), 32'h1);
    check("stop.tx_valid", 32'(tx_valid), 32'h1);
    check("stop.tx_zero", 32'(tx_data), 32'h00);
    idle(); cycle();
    check("stop.tx_done", 32'(tx_valid), 32'h0);
    check("stop.sticky", 32'(program_stop), 32'h1);
    tx_ready = 1'b0;
    reset_dut();
    check("stop.cleared", 32'(program_stop), 32'h0);

    // In-flight read killed by reset; RAM survives reset
    bus(32'h0000_0010, 1'b0, 8'h00); rst_in = 1'b1; cycle(); rst_in = 1'b0;
    check("rstread.zero", 32'(cpu_rdata), 32'h00);
    cycle();
    check("rstread.ram_kept", 32'(cpu_rdata), 32'hA5);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_in   = ($urandom % 300) == 0;
      tx_ready = ($urandom % 3) == 0;
      rx_valid = ($urandom % 2) == 0;
      rx_data  = 8'($urandom);
      case ($urandom % 5)
        0: bus(rand_ram_addr(), 1'b1, 8'($urandom));
        1: bus(rand_ram_addr(), 1'b0, 8'h00);
        2: bus(32'h0003_0000 | 32'($urandom % 9), 1'b0, 8'h00);
        3: bus(32'h0003_0000, 1'b0, 8'h00);
        default: begin
          if ($urandom % 25 == 0) bus(32'h0003_0004, 1'b1, 8'($urandom));
          else if ($urandom % 10 == 0) bus(32'h0003_0006, 1'b1, 8'($urandom));
          else bus(32'h0003_0000, 1'b1, (($urandom % 8) == 0) ? 8'h00 : 8'($urandom));
        end
      endcase
      cycle();
    end
    rst_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
